// File: rtl/doodle_pkg.sv
// ---------------------------------------------------------------------------
// doodle_pkg
//   Shared definitions for the push-button conditioners.
//   - state_t   : 3-bit encoding of the debounce / pulse FSM states
//   - DEF_N_DC  : default debounce counter width (2^20 cycles ~ 10.5 ms @ 100 MHz)
//   - DEF_N_RPT : default auto-repeat counter width
//   - SIM_N_DC / SIM_N_RPT : short widths so simulations finish quickly
//   - cnt_width() : width of the shared state counter for a given build
// ---------------------------------------------------------------------------
package doodle_pkg;

    typedef enum logic [2:0] {
        ST_INI  = 3'd0,   // idle, button released
        ST_WQ   = 3'd1,   // press seen, waiting for quiet time
        ST_SCEN = 3'd2,   // one-cycle press pulse
        ST_WH   = 3'd3,   // held
        ST_MCEN = 3'd4,   // one-cycle auto-repeat pulse
        ST_WFQ  = 3'd5    // release seen, waiting for quiet time
    } state_t;

    localparam int DEF_N_DC  = 20;
    localparam int DEF_N_RPT = 26;
    localparam int SIM_N_DC  = 4;
    localparam int SIM_N_RPT = 5;

    // The counter only has to reach 2^N_RPT-1 when auto-repeat is built in.
    function automatic int cnt_width(input int n_dc, input int n_rpt, input bit rpt_en);
        return (rpt_en && (n_rpt > n_dc)) ? n_rpt : n_dc;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-stage synchronizer for an asynchronous pad input. Both stages clear
//   to 0 on reset. Reusable for any single-bit pad.
//   Ports:
//     board_clk in  : destination clock, rising edge
//     reset     in  : asynchronous, active-high
//     d         in  : asynchronous input
//     q         out : synchronized output (two board_clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic board_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse
//   Conditions one raw push-button: synchronizes it, debounces it with a
//   quiet-time counter, and produces a debounced level plus a single-cycle
//   enable pulse per accepted press.
//
//   Build option: define BTN_AUTOREPEAT_MCEN_EN to add the auto-repeat state;
//   mcen then pulses with the press and every 2^N_RPT+1 cycles while held.
//   Without it mcen is constant 0 and N_RPT has no effect.
//
//   Parameters:
//     N_DC  : debounce counter width, quiet time = 2^N_DC cycles
//     N_RPT : auto-repeat counter width (auto-repeat builds only)
//   Ports:
//     board_clk in  : system clock, rising edge
//     reset     in  : asynchronous, active-high
//     btn_in    in  : raw bouncing button pad, active-high
//     db_out    out : debounced button level
//     scen      out : one-cycle pulse per accepted press
//     mcen      out : press + auto-repeat pulses (0 without auto-repeat)
// ---------------------------------------------------------------------------
module btn_debounce_pulse
    import doodle_pkg::*;
#(
    parameter int N_DC  = DEF_N_DC,
    parameter int N_RPT = DEF_N_RPT
) (
    input  logic board_clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_out,
    output logic scen,
    output logic mcen
);

`ifdef BTN_AUTOREPEAT_MCEN_EN
    localparam bit MCEN_EN = 1'b1;
`else
    localparam bit MCEN_EN = 1'b0;
`endif

    localparam int CNT_W = cnt_width(N_DC, N_RPT, MCEN_EN);
    localparam logic [CNT_W-1:0] MAX_DC = CNT_W'((2 ** N_DC) - 1);
`ifdef BTN_AUTOREPEAT_MCEN_EN
    localparam logic [CNT_W-1:0] MAX_RPT = CNT_W'((2 ** N_RPT) - 1);
`endif

    logic             btn_s;
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_inc;

    sync_2ff u_sync (
        .board_clk (board_clk),
        .reset     (reset),
        .d         (btn_in),
        .q         (btn_s)
    );

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_INI;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic. Where a drop/release and a terminal count coincide,
    // the level check comes first so the button state always wins.
    always_comb begin
        state_next = state_reg;
        cnt_inc    = 1'b0;
        case (state_reg)
            ST_INI: begin
                if (btn_s) state_next = ST_WQ;
            end
            ST_WQ: begin
                cnt_inc = 1'b1;
                if (!btn_s)                 state_next = ST_INI;
                else if (cnt_reg == MAX_DC) state_next = ST_SCEN;
            end
            ST_SCEN: begin
                state_next = ST_WH;
            end
            ST_WH: begin
`ifdef BTN_AUTOREPEAT_MCEN_EN
                cnt_inc = 1'b1;
                if (!btn_s)                  state_next = ST_WFQ;
                else if (cnt_reg == MAX_RPT) state_next = ST_MCEN;
`else
                if (!btn_s) state_next = ST_WFQ;
`endif
            end
`ifdef BTN_AUTOREPEAT_MCEN_EN
            ST_MCEN: begin
                state_next = ST_WH;
            end
`endif
            ST_WFQ: begin
                cnt_inc = 1'b1;
                if (btn_s)                  state_next = ST_WH;
                else if (cnt_reg == MAX_DC) state_next = ST_INI;
            end
            default: begin
                state_next = ST_INI;
            end
        endcase
    end

    // Every state change restarts the count so each wait measures time
    // spent in its own state only.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) cnt_next = '0;
        else if (cnt_inc)            cnt_next = cnt_reg + CNT_W'(1);
    end

    // Moore outputs: decoded from the state register only.
    always_comb begin
        db_out = 1'b0;
        scen   = 1'b0;
        mcen   = 1'b0;
        case (state_reg)
            ST_SCEN: begin
                db_out = 1'b1;
                scen   = 1'b1;
                mcen   = MCEN_EN;
            end
            ST_WH:   db_out = 1'b1;
`ifdef BTN_AUTOREPEAT_MCEN_EN
            ST_MCEN: begin
                db_out = 1'b1;
                mcen   = 1'b1;
            end
`endif
            ST_WFQ:  db_out = 1'b1;
            default: begin
                db_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_pulse
//   Directed bench for btn_debounce_pulse with N_DC=4, N_RPT=5.
//   Offsets are counted in clock edges from the first edge that samples the
//   new btn_in value (offset 0). A press reaches SCEN at offset 18; a release
//   returns to INI at offset 18 after the first edge sampling stable 0.
//   Define BTN_AUTOREPEAT_MCEN_EN for both bench and RTL to check auto-repeat.
// ---------------------------------------------------------------------------
module tb_btn_debounce_pulse;
    import doodle_pkg::*;

`ifdef BTN_AUTOREPEAT_MCEN_EN
    localparam bit MCEN_BUILD = 1'b1;
`else
    localparam bit MCEN_BUILD = 1'b0;
`endif

    logic board_clk = 1'b0;
    logic reset     = 1'b1;
    logic btn_in    = 1'b0;
    logic db_out;
    logic scen;
    logic mcen;

    int errors      = 0;
    int checks      = 0;
    int scen_pulses = 0;
    int presses     = 0;

    btn_debounce_pulse #(
        .N_DC  (SIM_N_DC),
        .N_RPT (SIM_N_RPT)
    ) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .db_out    (db_out),
        .scen      (scen),
        .mcen      (mcen)
    );

    always #5 board_clk = ~board_clk;

    always @(posedge board_clk) begin
        if (scen === 1'b1) scen_pulses++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive btn_in so the next edge samples it, then move 1 ns past that edge.
    task automatic step(input logic b);
        btn_in = b;
        @(posedge board_clk);
        #1;
    endtask

    function automatic int exp_mcen(input int i);
        return int'(MCEN_BUILD && (i >= 18) && (((i - 18) % 33) == 0));
    endfunction

    // Hold the button from a clean idle state for n edges.
    task automatic run_hold(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            chk({tag, "/scen"}, int'(scen),   int'(i == 18));
            chk({tag, "/db"},   int'(db_out), int'(i >= 18));
            chk({tag, "/mcen"}, int'(mcen),   exp_mcen(i));
        end
        if (n > 18) presses++;
        $display("press %s: held %0d cycles", tag, n);
    endtask

    // Release from the held state for n edges of stable 0.
    task automatic run_release(input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            step(1'b0);
            chk({tag, "/scen"}, int'(scen), 0);
            chk({tag, "/mcen"}, int'(mcen), 0);
            if (j <= 16)      chk({tag, "/db_hi"}, int'(db_out), 1);
            else if (j >= 18) chk({tag, "/db_lo"}, int'(db_out), 0);
        end
        $display("release %s: low %0d cycles", tag, n);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge board_clk);
        #1;
        chk("rst/db",   int'(db_out), 0);
        chk("rst/scen", int'(scen),   0);
        chk("rst/mcen", int'(mcen),   0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("idle/db",   int'(db_out), 0);
            chk("idle/scen", int'(scen),   0);
        end
        $display("reset: outputs idle");

        // Clean press held 120 cycles (covers auto-repeat), then release
        run_hold(120, "clean");
        run_release(30, "clean_rel");

        // Bounce: toggle every 3 cycles for 30 cycles, then low
        for (int i = 0; i < 55; i++) begin
            step((i < 30) ? (((i / 3) % 2) == 0) : 1'b0);
            chk("bounce/scen", int'(scen),   0);
            chk("bounce/db",   int'(db_out), 0);
            chk("bounce/mcen", int'(mcen),   0);
        end
        $display("bounce: 30 chatter cycles rejected");

        // Release bounce: no second pulse, level held through chatter
        run_hold(25, "rb");
        for (int c = 0; c < 6; c++) begin
            step((c % 2) == 1);
            chk("rb_chatter/scen", int'(scen),   0);
            chk("rb_chatter/db",   int'(db_out), 1);
            chk("rb_chatter/mcen", int'(mcen),   0);
        end
        run_release(25, "rb_rel");

        // Reset mid-WQ (count at 8), then press needs the full 18 edges
        for (int i = 0; i < 11; i++) begin
            step(1'b1);
            chk("wq/db",   int'(db_out), 0);
            chk("wq/scen", int'(scen),   0);
        end
        reset = 1'b1;
        #1;
        chk("wq_rst/db",   int'(db_out), 0);
        chk("wq_rst/scen", int'(scen),   0);
        chk("wq_rst/mcen", int'(mcen),   0);
        step(1'b1);
        step(1'b1);
        reset = 1'b0;
        $display("reset: asserted mid-debounce");
        run_hold(30, "after_rst");

        // Reset while held drops the level at once
        reset = 1'b1;
        #1;
        chk("wh_rst/db",   int'(db_out), 0);
        chk("wh_rst/scen", int'(scen),   0);
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("wh_rst_idle/db", int'(db_out), 0);
        end
        $display("reset: asserted while held");

        // Back-to-back presses separated by 20 low cycles
        run_hold(25, "b2b_1");
        run_release(20, "b2b_gap");
        run_hold(25, "b2b_2");
        run_release(25, "b2b_rel");

        chk("scen_pulse_count", scen_pulses, presses);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
